// File: rtl/spw_token_tx.sv
// rtl/spw_token_tx.sv - SpaceWire token serializer (D/S encoder with odd parity)
//
// Purpose: serializes NULL, FCT, EOP, EEP, N-char and time-code tokens onto
// the SpaceWire data/strobe pair. Tokens are loaded one per LOAD cycle, and
// an auto-NULL is sent when no request is pending, so the line never idles
// while the link is enabled.
//
// Ports:
//   i_clock_sys  in   1  system clock, rising edge
//   i_tx_resetn  in   1  synchronous active-low reset
//   i_tx_enable  in   1  1 = transmit, 0 = line forced idle
//   i_tx_req     in   1  token request, held until o_tx_ack
//   i_tx_type    in   3  0 NULL,1 FCT,2 EOP,3 EEP,4 N-char,5 time-code,6/7 as NULL
//   i_tx_data    in   8  N-char / time-code value, sent LSB first
//   o_tx_ack     out  1  one-cycle pulse when the request is loaded
//   o_tx_busy    out  1  high while a token is being shifted
//   o_tx_dout    out  1  SpaceWire data line
//   o_tx_sout    out  1  SpaceWire strobe line

module spw_token_tx #(
    parameter int BIT_DIV = 4
) (
    input  logic       i_clock_sys,
    input  logic       i_tx_resetn,
    input  logic       i_tx_enable,
    input  logic       i_tx_req,
    input  logic [2:0] i_tx_type,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_ack,
    output logic       o_tx_busy,
    output logic       o_tx_dout,
    output logic       o_tx_sout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    localparam logic [7:0] DIV_LAST  = 8'(BIT_DIV - 1);
    // The last bit of a token ends one cycle early in SHIFT because the
    // following LOAD cycle supplies the final cycle of that bit period.
    localparam logic [7:0] DIV_EARLY = 8'(BIT_DIV - 2);

    logic [1:0]  r_state;
    logic [13:0] r_shift;
    logic [3:0]  r_len;
    logic [3:0]  r_bitcnt;
    logic [7:0]  r_timer;
    logic        r_hist;     // XOR of the previous character's data bits
    logic        r_dout;
    logic        r_sout;

    logic [2:0]  w_type;
    logic [13:0] w_bits;     // bit 0 is transmitted first
    logic [3:0]  w_len;
    logic        w_hist_next;
    logic        w_last_bit;

    // Without a request an auto-NULL is loaded (type 0).
    assign w_type = i_tx_req ? i_tx_type : 3'd0;

    // Parity P = ~(history ^ flag). Inside NULL and time-code the ESC data
    // bits are 1,1, so the second character always sees a history of 0.
    always_comb begin
        w_bits      = 14'd0;
        w_len       = 4'd8;
        w_hist_next = 1'b0;
        case (w_type)
            3'd1: begin
                w_bits[3:0] = {1'b0, 1'b0, 1'b1, r_hist};
                w_len       = 4'd4;
            end
            3'd2: begin
                w_bits[3:0] = {1'b1, 1'b0, 1'b1, r_hist};
                w_len       = 4'd4;
                w_hist_next = 1'b1;
            end
            3'd3: begin
                w_bits[3:0] = {1'b0, 1'b1, 1'b1, r_hist};
                w_len       = 4'd4;
                w_hist_next = 1'b1;
            end
            3'd4: begin
                w_bits[9:0] = {i_tx_data, 1'b0, ~r_hist};
                w_len       = 4'd10;
                w_hist_next = ^i_tx_data;
            end
            3'd5: begin
                w_bits      = {i_tx_data, 1'b0, 1'b1, 3'b111, r_hist};
                w_len       = 4'd14;
                w_hist_next = ^i_tx_data;
            end
            default: begin
                // NULL: ESC (P,1,1,1) then FCT (0,1,0,0); reserved types too.
                w_bits[7:0] = {1'b0, 1'b0, 1'b1, 1'b0, 3'b111, r_hist};
                w_len       = 4'd8;
            end
        endcase
    end

    assign w_last_bit = (r_bitcnt == r_len);

    always_ff @(posedge i_clock_sys) begin
        if (!i_tx_resetn || !i_tx_enable) begin
            r_state  <= ST_IDLE;
            r_shift  <= 14'd0;
            r_len    <= 4'd0;
            r_bitcnt <= 4'd0;
            r_timer  <= 8'd0;
            r_hist   <= 1'b0;
            r_dout   <= 1'b0;
            r_sout   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_dout   <= w_bits[0];
                    // Strobe toggles only when data repeats, so D^S flips every bit.
                    r_sout   <= (w_bits[0] == r_dout) ? ~r_sout : r_sout;
                    r_shift  <= {1'b0, w_bits[13:1]};
                    r_len    <= w_len;
                    r_bitcnt <= 4'd1;
                    r_timer  <= 8'd0;
                    r_hist   <= w_hist_next;
                    r_state  <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_last_bit && (r_timer == DIV_EARLY)) begin
                        r_timer <= 8'd0;
                        r_state <= ST_LOAD;
                    end else if (r_timer == DIV_LAST) begin
                        r_dout   <= r_shift[0];
                        r_sout   <= (r_shift[0] == r_dout) ? ~r_sout : r_sout;
                        r_shift  <= {1'b0, r_shift[13:1]};
                        r_bitcnt <= r_bitcnt + 4'd1;
                        r_timer  <= 8'd0;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // A LOAD cut short by reset or disable is abandoned, so no ack then.
    assign o_tx_ack  = (r_state == ST_LOAD) && i_tx_req && i_tx_enable && i_tx_resetn;
    assign o_tx_busy = (r_state == ST_SHIFT);
    assign o_tx_dout = r_dout;
    assign o_tx_sout = r_sout;

endmodule

// File: tb/tb_spw_token_tx.sv
// tb/tb_spw_token_tx.sv - scoreboard bench for spw_token_tx

module tb_spw_token_tx;

    localparam int BD = 2;

    logic       clk;
    logic       resetn;
    logic       en;
    logic       req;
    logic [2:0] ttype;
    logic [7:0] tdata;
    logic       ack;
    logic       busy;
    logic       dout;
    logic       sout;

    int checks   = 0;
    int failures = 0;
    int exp_acks = 0;
    int dut_acks = 0;

    bit exp_q[$];

    // monitor state
    bit m_prev_x;
    bit m_prev_d;
    bit m_prev_s;
    bit m_d;
    bit m_s;
    bit m_first;
    int m_cnt;

    spw_token_tx #(.BIT_DIV(BD)) dut (
        .i_clock_sys (clk),
        .i_tx_resetn (resetn),
        .i_tx_enable (en),
        .i_tx_req    (req),
        .i_tx_type   (ttype),
        .i_tx_data   (tdata),
        .o_tx_ack    (ack),
        .o_tx_busy   (busy),
        .o_tx_dout   (dout),
        .o_tx_sout   (sout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1ns into a LOAD cycle; returns 1ns into the next LOAD cycle.
    // bits: hand-computed line sequence in transmit order.
    task automatic send(input bit r, input logic [2:0] t, input logic [7:0] d,
                        input string bits, input bit keep);
        int n;
        n = bits.len();
        req   = r;
        ttype = t;
        tdata = d;
        for (int i = 0; i < n; i++) exp_q.push_back(bits[i] == 8'h31);
        if (r) exp_acks++;
        #1;
        chk("ack_in_load", int'(ack), int'(r));
        chk("busy_in_load", int'(busy), 0);
        wait_cycles(1);
        chk("busy_in_shift", int'(busy), 1);
        if (!keep) req = 1'b0;
        wait_cycles(n * BD - 1);
    endtask

    // Monitor: every D^S transition is a new bit; compare against the queue.
    always @(negedge clk) begin
        if (ack) dut_acks++;
        if (!resetn || !en) begin
            m_prev_x = 1'b0;
            m_prev_d = 1'b0;
            m_prev_s = 1'b0;
            m_d      = 1'b0;
            m_s      = 1'b0;
            m_first  = 1'b1;
            m_cnt    = 0;
        end else begin
            m_cnt++;
            if ((dout ^ sout) != m_prev_x) begin
                chk("one_line_changes", int'((dout != m_prev_d) ^ (sout != m_prev_s)), 1);
                if (!m_first) chk("bit_period", m_cnt, BD);
                m_first = 1'b0;
                m_cnt   = 0;
                chk("bit_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("dout_bit", int'(dout), int'(exp_q.pop_front()));
                if (dout == m_d) m_s = ~m_s;
                m_d = dout;
                chk("sout_bit", int'(sout), int'(m_s));
            end
            m_prev_x = dout ^ sout;
            m_prev_d = dout;
            m_prev_s = sout;
        end
    end

    initial begin
        resetn = 1'b0;
        en     = 1'b0;
        req    = 1'b0;
        ttype  = 3'd0;
        tdata  = 8'd0;
        wait_cycles(4);
        chk("reset_dout", int'(dout), 0);
        chk("reset_sout", int'(sout), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ack",  int'(ack), 0);

        // T1: auto NULLs from reset
        resetn = 1'b1;
        en     = 1'b1;
        wait_cycles(1);
        send(1'b0, 3'd0, 8'h00, "01110100", 1'b0);
        send(1'b0, 3'd0, 8'h00, "01110100", 1'b0);

        // T2: N-char 0x55 then EOP, then auto NULL with history 1
        send(1'b1, 3'd4, 8'h55, "1010101010", 1'b0);
        send(1'b1, 3'd2, 8'h00, "0101", 1'b0);
        send(1'b0, 3'd0, 8'h00, "11110100", 1'b0);

        // T3: time-code 0x3F
        send(1'b1, 3'd5, 8'h3F, "01111011111100", 1'b0);

        // T5: FCT with request held for three tokens
        send(1'b1, 3'd1, 8'h00, "0100", 1'b1);
        send(1'b1, 3'd1, 8'h00, "0100", 1'b1);
        send(1'b1, 3'd1, 8'h00, "0100", 1'b0);

        // More patterns: EEP, N-char with parity from EEP, reserved type, 0x80
        send(1'b1, 3'd3, 8'h00, "0110", 1'b0);
        send(1'b1, 3'd4, 8'h00, "0000000000", 1'b0);
        send(1'b1, 3'd6, 8'h00, "01110100", 1'b0);
        send(1'b1, 3'd4, 8'h80, "1000000001", 1'b0);
        send(1'b0, 3'd0, 8'h00, "11110100", 1'b0);

        // T4: drop enable in the second cycle of bit 5 of an N-char
        req   = 1'b1;
        ttype = 3'd4;
        tdata = 8'h55;
        for (int i = 0; i < 10; i++) exp_q.push_back(i[0] == 1'b0);
        exp_acks++;
        #1;
        chk("ack_t4", int'(ack), 1);
        wait_cycles(1);
        req = 1'b0;
        wait_cycles(11);
        chk("t4_remaining_bits", exp_q.size(), 4);
        en = 1'b0;
        exp_q.delete();
        wait_cycles(1);
        chk("t4_dout", int'(dout), 0);
        chk("t4_sout", int'(sout), 0);
        chk("t4_busy", int'(busy), 0);
        en = 1'b1;
        wait_cycles(1);
        send(1'b0, 3'd0, 8'h00, "01110100", 1'b0);
        send(1'b0, 3'd0, 8'h00, "01110100", 1'b0);

        en = 1'b0;
        wait_cycles(2);
        chk("queue_drained", exp_q.size(), 0);
        chk("ack_count", dut_acks, exp_acks);
        chk("idle_dout", int'(dout), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
